// File: rtl/periph_initiator.sv
// Single-outstanding bus initiator for one accelerator peripheral slot.
// Takes read/write commands on a valid/ready port, runs one strobe/ack cycle, returns the response.
module periph_initiator #(
    parameter int address_width  = 22,
    parameter int data_width     = 2,
    parameter int timeout_cycles = 64
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            REQ_VALID,
    output logic                            REQ_READY,
    input  logic                            REQ_WRITE,
    input  logic [address_width-1:0]        REQ_ADDR,
    input  logic [(1<<data_width)*8-1:0]    REQ_WDATA,
    input  logic [(1<<data_width)-1:0]      REQ_BE,
    output logic                            RSP_VALID,
    input  logic                            RSP_READY,
    output logic [(1<<data_width)*8-1:0]    RSP_RDATA,
    output logic                            RSP_ERROR,
    output logic [address_width-1:0]        P_READ_ADDR,
    output logic                            P_OE,
    input  logic [(1<<data_width)*8-1:0]    P_RDATA,
    input  logic                            P_DATA_VALID,
    output logic [address_width-1:0]        P_WRITE_ADDR,
    output logic [(1<<data_width)*8-1:0]    P_WDATA,
    output logic [(1<<data_width)-1:0]      P_BE,
    output logic                            P_WE,
    input  logic                            P_WACK
);

    localparam int DBITS = (1 << data_width) * 8;
    localparam int BEW   = 1 << data_width;
    localparam int CNT_W = $clog2(timeout_cycles + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                     r_state, w_state_next;
    logic                       r_cmd_write, w_cmd_write_next;
    logic [CNT_W-1:0]           r_count, w_count_next;
    logic                       r_req_ready, w_req_ready_next;
    logic                       r_rsp_valid, w_rsp_valid_next;
    logic [DBITS-1:0]           r_rsp_rdata, w_rsp_rdata_next;
    logic                       r_rsp_error, w_rsp_error_next;
    logic [address_width-1:0]   r_p_read_addr, w_p_read_addr_next;
    logic [address_width-1:0]   r_p_write_addr, w_p_write_addr_next;
    logic [DBITS-1:0]           r_p_wdata, w_p_wdata_next;
    logic [BEW-1:0]             r_p_be, w_p_be_next;
    logic                       r_p_oe, w_p_oe_next;
    logic                       r_p_we, w_p_we_next;
    logic                       w_ack;
    logic                       w_timeout;

    // Only the ack belonging to the current direction can complete a transaction.
    assign w_ack     = r_cmd_write ? P_WACK : P_DATA_VALID;
    assign w_timeout = (r_count == CNT_W'(timeout_cycles - 1));

    always_comb begin
        w_state_next        = r_state;
        w_cmd_write_next    = r_cmd_write;
        w_count_next        = r_count;
        w_req_ready_next    = r_req_ready;
        w_rsp_valid_next    = r_rsp_valid;
        w_rsp_rdata_next    = r_rsp_rdata;
        w_rsp_error_next    = r_rsp_error;
        w_p_read_addr_next  = r_p_read_addr;
        w_p_write_addr_next = r_p_write_addr;
        w_p_wdata_next      = r_p_wdata;
        w_p_be_next         = r_p_be;
        w_p_oe_next         = r_p_oe;
        w_p_we_next         = r_p_we;

        case (r_state)
            S_IDLE: begin
                w_req_ready_next = 1'b1;
                if (REQ_VALID && r_req_ready) begin
                    w_req_ready_next = 1'b0;
                    w_cmd_write_next = REQ_WRITE;
                    if (REQ_WRITE && (REQ_BE == '0)) begin
                        // Nothing to write: complete immediately without touching the bus.
                        w_rsp_valid_next = 1'b1;
                        w_rsp_error_next = 1'b0;
                        w_rsp_rdata_next = '0;
                        w_state_next     = S_RESP;
                    end else if (REQ_WRITE) begin
                        w_p_we_next         = 1'b1;
                        w_p_write_addr_next = REQ_ADDR;
                        w_p_wdata_next      = REQ_WDATA;
                        w_p_be_next         = REQ_BE;
                        w_state_next        = S_ISSUE;
                    end else begin
                        w_p_oe_next        = 1'b1;
                        w_p_read_addr_next = REQ_ADDR;
                        w_state_next       = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // Acks seen here may be left over from the previous transaction.
                w_count_next = '0;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_ack || w_timeout) begin
                    w_p_oe_next      = 1'b0;
                    w_p_we_next      = 1'b0;
                    w_p_be_next      = '0;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_error_next = !w_ack;
                    w_rsp_rdata_next = (w_ack && !r_cmd_write) ? P_RDATA : '0;
                    w_state_next     = S_RESP;
                end else begin
                    w_count_next = r_count + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (RSP_READY) begin
                    w_rsp_valid_next = 1'b0;
                    w_req_ready_next = 1'b1;
                    w_state_next     = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= S_IDLE;
            r_cmd_write    <= 1'b0;
            r_count        <= '0;
            r_req_ready    <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= '0;
            r_rsp_error    <= 1'b0;
            r_p_read_addr  <= '0;
            r_p_write_addr <= '0;
            r_p_wdata      <= '0;
            r_p_be         <= '0;
            r_p_oe         <= 1'b0;
            r_p_we         <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cmd_write    <= w_cmd_write_next;
            r_count        <= w_count_next;
            r_req_ready    <= w_req_ready_next;
            r_rsp_valid    <= w_rsp_valid_next;
            r_rsp_rdata    <= w_rsp_rdata_next;
            r_rsp_error    <= w_rsp_error_next;
            r_p_read_addr  <= w_p_read_addr_next;
            r_p_write_addr <= w_p_write_addr_next;
            r_p_wdata      <= w_p_wdata_next;
            r_p_be         <= w_p_be_next;
            r_p_oe         <= w_p_oe_next;
            r_p_we         <= w_p_we_next;
        end
    end

    assign REQ_READY    = r_req_ready;
    assign RSP_VALID    = r_rsp_valid;
    assign RSP_RDATA    = r_rsp_rdata;
    assign RSP_ERROR    = r_rsp_error;
    assign P_READ_ADDR  = r_p_read_addr;
    assign P_OE         = r_p_oe;
    assign P_WRITE_ADDR = r_p_write_addr;
    assign P_WDATA      = r_p_wdata;
    assign P_BE         = r_p_be;
    assign P_WE         = r_p_we;

endmodule
